// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle controller:
//   - 4-bit opcode constants (opcode = instr[INSTR_W-1:INSTR_W-4])
//   - FSM state encoding (also visible on state_dbg)
//   - ctrl_word field offsets/widths and the encodings of the select fields
// Fields occupy ctrl_word[CW_USED-1:0]; bits above that are tied to 0, so
// CTRL_W must be at least CW_USED.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Opcodes. Any code not listed here executes as a NOP.
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADI  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_LHI  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_LM   = 4'h6;
  localparam logic [3:0] OP_SM   = 4'h7;
  localparam logic [3:0] OP_JAL  = 4'h8;
  localparam logic [3:0] OP_JLR  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hC;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_R_READ  = 3'd3,
    S_EXECUTE = 3'd4,
    S_MEM_ACC = 3'd5,
    S_WR_BACK = 3'd6
  } state_e;

  // ctrl_word field offsets (single bits unless a _W width is given)
  localparam int CW_PC_LD    = 0;   // load PC
  localparam int CW_PC_SEL   = 1;   // PC source, CW_PC_SEL_W bits
  localparam int CW_PC_SEL_W = 2;
  localparam int CW_RF_WE    = 3;   // register-file write enable
  localparam int CW_RF_WSEL  = 4;   // RF write-data source, 2 bits
  localparam int CW_RF_WSEL_W = 2;
  localparam int CW_RF_DST   = 6;   // RF destination select, 2 bits
  localparam int CW_RF_DST_W = 2;
  localparam int CW_C_LD     = 8;   // carry flag load
  localparam int CW_Z_LD     = 9;   // zero flag load
  localparam int CW_ALU_OP   = 10;  // ALU operation, 2 bits
  localparam int CW_ALU_OP_W = 2;
  localparam int CW_ALU_BSEL = 12;  // ALU B operand: 0 = register, 1 = immediate
  localparam int CW_IR_LD    = 13;  // instruction register load
  localparam int CW_ADDR_SEL = 14;  // memory address: 0 = PC, 1 = address register
  localparam int CW_RF_RD    = 15;  // register-file read strobe
  localparam int CW_AREG_INC = 16;  // step LM/SM address register
  localparam int CW_MDR_LD   = 17;  // capture memory read data
  localparam int CW_USED     = 18;

  // PC source
  localparam logic [1:0] PCS_INC = 2'd0;  // PC + 1
  localparam logic [1:0] PCS_BR  = 2'd1;  // BEQ target
  localparam logic [1:0] PCS_JAL = 2'd2;  // PC + imm
  localparam logic [1:0] PCS_JLR = 2'd3;  // register value

  // RF write-data source
  localparam logic [1:0] WS_ALU = 2'd0;
  localparam logic [1:0] WS_MEM = 2'd1;
  localparam logic [1:0] WS_PC1 = 2'd2;
  localparam logic [1:0] WS_IMM = 2'd3;

  // RF destination: instr[5:3], instr[8:6], instr[11:9], or pe_idx
  localparam logic [1:0] DS_RC = 2'd0;
  localparam logic [1:0] DS_RB = 2'd1;
  localparam logic [1:0] DS_RA = 2'd2;
  localparam logic [1:0] DS_PE = 2'd3;

  // ALU operations
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_NAND = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;

  function automatic logic is_lmsm(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/mc_controller_p_if.sv
// ---------------------------------------------------------------------------
// mc_controller_p_if
// Bundle of the controller <-> datapath/memory signals.
//   master : the controller (drives ctrl_word, mem_req, mem_we, pe_idx,
//            state_dbg; observes instr, flags, eq, mem_ack)
//   slave  : the datapath/memory side (the reverse directions)
// ---------------------------------------------------------------------------
interface mc_controller_p_if #(
  parameter int INSTR_W   = 16,
  parameter int REGLIST_W = 8,
  parameter int CTRL_W    = 24
);
  logic [INSTR_W-1:0]           instr;
  logic                         cflag;
  logic                         zflag;
  logic                         eq;
  logic                         mem_ack;
  logic [CTRL_W-1:0]            ctrl_word;
  logic                         mem_req;
  logic                         mem_we;
  logic [$clog2(REGLIST_W)-1:0] pe_idx;
  logic [2:0]                   state_dbg;

  modport master (
    input  instr, cflag, zflag, eq, mem_ack,
    output ctrl_word, mem_req, mem_we, pe_idx, state_dbg
  );

  modport slave (
    output instr, cflag, zflag, eq, mem_ack,
    input  ctrl_word, mem_req, mem_we, pe_idx, state_dbg
  );
endinterface

// File: rtl/lsb_prio_enc.sv
// ---------------------------------------------------------------------------
// lsb_prio_enc
// Lowest-set-bit priority encoder (purely combinational).
//   vec     in  W            input vector (W >= 2)
//   idx     out $clog2(W)    index of the lowest set bit, 0 when vec == 0
//   any_set out 1            vec != 0
// ---------------------------------------------------------------------------
module lsb_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 any_set
);
  localparam int IDX_W = $clog2(W);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any_set = |vec;
endmodule

// File: rtl/mc_controller_p.sv
// ---------------------------------------------------------------------------
// mc_controller_p
// Multi-cycle processor control unit. FSM:
//   RESET -> FETCH -> DECODE -> R_READ -> EXECUTE -> (MEM_ACC) -> WR_BACK
// LM/SM walk a register-list mask one set bit at a time, lowest index first.
//
// Ports
//   clk        in   1                  rising-edge clock
//   resetn     in   1                  asynchronous active-low reset
//   instr      in   INSTR_W            current IR contents
//   cflag      in   1                  carry flag
//   zflag      in   1                  zero flag
//   eq         in   1                  BEQ compare result
//   mem_ack    in   1                  memory transfer complete
//   ctrl_word  out  CTRL_W             datapath control fields (mc_ctrl_pkg)
//   mem_req    out  1                  memory request (FETCH, MEM_ACC)
//   mem_we     out  1                  memory write strobe (MEM_ACC of SW/SM)
//   pe_idx     out  $clog2(REGLIST_W)  current LM/SM register index
//   state_dbg  out  3                  encoded FSM state
//
// Build option: define CTRL_MEM_WAIT_EN to make FETCH and MEM_ACC wait for
// mem_ack. Without it mem_ack is ignored and both states last one cycle.
// ---------------------------------------------------------------------------
module mc_controller_p
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W   = 16,
  parameter int REGLIST_W = 8,   // legal range 2 .. INSTR_W-4
  parameter int CTRL_W    = 24   // must be >= CW_USED
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [INSTR_W-1:0]           instr,
  input  logic                         cflag,
  input  logic                         zflag,
  input  logic                         eq,
  input  logic                         mem_ack,
  output logic [CTRL_W-1:0]            ctrl_word,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [$clog2(REGLIST_W)-1:0] pe_idx,
  output logic [2:0]                   state_dbg
);

  state_e                 state_q, state_d;
  logic [REGLIST_W-1:0]   mask_q, mask_d;
  logic [REGLIST_W-1:0]   mask_rest;
  logic                   mask_any;
  logic [3:0]             opcode;
  logic                   lmsm;
  logic                   squash;
  logic                   mem_go;
  logic [CTRL_W-1:0]      cw;

  assign opcode = instr[INSTR_W-1 -: 4];
  assign lmsm   = is_lmsm(opcode);

  // ADC/ADZ-style conditional forms: the op is dropped when its flag is clear.
  assign squash = ((opcode == OP_ADD) || (opcode == OP_NAND)) &&
                  ((instr[1] && !cflag) || (instr[0] && !zflag));

`ifdef CTRL_MEM_WAIT_EN
  assign mem_go = mem_ack;
`else
  logic unused_mem_ack;
  assign unused_mem_ack = mem_ack;
  assign mem_go = 1'b1;
`endif

  // Only opcode and register-list bits steer the controller; the remaining
  // instruction fields are consumed by the datapath.
  logic unused_instr;
  assign unused_instr = ^instr;

  lsb_prio_enc #(.W(REGLIST_W)) u_prio_enc (
    .vec     (mask_q),
    .idx     (pe_idx),
    .any_set (mask_any)
  );

  // Mask with its lowest set bit removed: what remains after this WR_BACK.
  assign mask_rest = mask_q & (mask_q - REGLIST_W'(1));

  // Next-state and mask update
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH:   if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_R_READ;
        mask_d  = lmsm ? instr[REGLIST_W-1:0] : '0;
      end
      S_R_READ:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        // An empty LM/SM list goes straight to WR_BACK with no transfer.
        if ((opcode == OP_LW) || (opcode == OP_SW) || (lmsm && mask_any))
          state_d = S_MEM_ACC;
        else
          state_d = S_WR_BACK;
      end
      S_MEM_ACC: if (mem_go) state_d = S_WR_BACK;
      S_WR_BACK: begin
        state_d = S_FETCH;
        if (lmsm) begin
          mask_d = mask_rest;
          // LM re-enters EXECUTE (address step only); SM must re-read the
          // next source register first.
          if (|mask_rest) state_d = (opcode == OP_LM) ? S_EXECUTE : S_R_READ;
        end
      end
      default:   state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_RESET;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Control outputs: decoded from the current state, instr, flags and mask.
  always_comb begin
    cw      = '0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req       = 1'b1;
        cw[CW_IR_LD]  = 1'b1;
      end
      S_R_READ: cw[CW_RF_RD] = 1'b1;
      S_EXECUTE: begin
        case (opcode)
          OP_ADD: begin
            cw[CW_ALU_OP +: CW_ALU_OP_W] = ALU_ADD;
            cw[CW_C_LD] = !squash;
            cw[CW_Z_LD] = !squash;
          end
          OP_ADI: begin
            cw[CW_ALU_OP +: CW_ALU_OP_W] = ALU_ADD;
            cw[CW_ALU_BSEL] = 1'b1;
            cw[CW_C_LD]     = 1'b1;
            cw[CW_Z_LD]     = 1'b1;
          end
          OP_NAND: begin
            cw[CW_ALU_OP +: CW_ALU_OP_W] = ALU_NAND;
            cw[CW_Z_LD] = !squash;
          end
          OP_LW, OP_SW: begin
            cw[CW_ALU_OP +: CW_ALU_OP_W] = ALU_ADD;
            cw[CW_ALU_BSEL] = 1'b1;
          end
          OP_BEQ: cw[CW_ALU_OP +: CW_ALU_OP_W] = ALU_SUB;
          default: ;
        endcase
      end
      S_MEM_ACC: begin
        mem_req          = 1'b1;
        mem_we           = (opcode == OP_SW) || (opcode == OP_SM);
        cw[CW_ADDR_SEL]  = 1'b1;
        cw[CW_MDR_LD]    = (opcode == OP_LW) || (opcode == OP_LM);
      end
      S_WR_BACK: begin
        // PC is held while more LM/SM iterations remain.
        cw[CW_PC_LD] = !(lmsm && (|mask_rest));
        case (opcode)
          OP_ADD, OP_NAND: begin
            cw[CW_RF_WE] = !squash;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_ALU;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_RC;
          end
          OP_ADI: begin
            cw[CW_RF_WE] = 1'b1;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_ALU;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_RB;
          end
          OP_LHI: begin
            cw[CW_RF_WE] = 1'b1;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_IMM;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_RA;
          end
          OP_LW: begin
            cw[CW_RF_WE] = 1'b1;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_MEM;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_RA;
          end
          OP_LM: begin
            cw[CW_RF_WE]    = mask_any;
            cw[CW_AREG_INC] = mask_any;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_MEM;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_PE;
          end
          OP_SM: cw[CW_AREG_INC] = mask_any;
          OP_JAL: begin
            cw[CW_RF_WE] = 1'b1;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_PC1;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_RA;
            cw[CW_PC_SEL  +: CW_PC_SEL_W]  = PCS_JAL;
          end
          OP_JLR: begin
            cw[CW_RF_WE] = 1'b1;
            cw[CW_RF_WSEL +: CW_RF_WSEL_W] = WS_PC1;
            cw[CW_RF_DST  +: CW_RF_DST_W]  = DS_RA;
            cw[CW_PC_SEL  +: CW_PC_SEL_W]  = PCS_JLR;
          end
          OP_BEQ: cw[CW_PC_SEL +: CW_PC_SEL_W] = eq ? PCS_BR : PCS_INC;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctrl_word = cw;
  assign state_dbg = state_q;

endmodule
